// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between a requester and mem_access_ctrl.
// Requests use valid/ready. Responses are a one-cycle rsp_valid pulse with no ready.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Turns valid/ready requests into glitch-free Memory_unit latch strobes (SETUP/STROBE/HOLD), plus a zero-fill clear.
// One access per 3+STROBE_CYCLES cycles, read data returned in HOLD; req_ready is low whenever not IDLE or clear_start is high.
module mem_access_ctrl #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 3,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  req,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_bus,
  input  logic [DATA_W-1:0] mem_out_bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0]        STB_LAST  = 4'(STROBE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = '1;

  state_t            state, state_n;
  logic [3:0]        stb_cnt, stb_cnt_n;
  logic [ADDR_W-1:0] word_cnt, word_cnt_n, addr_n;
  logic [DATA_W-1:0] data_n;
  logic              op_n, clearing_n;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              accept, stb_last;

  assign req.req_ready = rst_n && (state == IDLE) && !clear_start;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_rdata = rsp_rdata_q;
  assign accept        = req.req_valid && req.req_ready;
  assign stb_last      = (stb_cnt == STB_LAST);

  always_comb begin
    state_n    = state;
    stb_cnt_n  = stb_cnt;
    word_cnt_n = word_cnt;
    clearing_n = clear_busy;
    op_n       = mem_op;
    addr_n     = mem_address;
    data_n     = mem_in_bus;
    case (state)
      IDLE: begin
        if (clear_start) begin
          clearing_n = 1'b1;
          word_cnt_n = '0;
          op_n       = 1'b1;
          addr_n     = '0;
          data_n     = '0;
          state_n    = SETUP;
        end else if (accept) begin
          op_n    = req.req_write;
          addr_n  = req.req_addr;
          data_n  = req.req_wdata;
          state_n = SETUP;
        end
      end
      SETUP: begin
        stb_cnt_n = '0;
        state_n   = STROBE;
      end
      STROBE: begin
        if (stb_last) state_n = HOLD;
        else          stb_cnt_n = stb_cnt + 4'd1;
      end
      HOLD: begin
        // The clear walks addresses upward and stops at the top word without wrapping.
        if (clear_busy && (word_cnt != WORD_LAST)) begin
          word_cnt_n = word_cnt + 1'b1;
          addr_n     = word_cnt + 1'b1;
          state_n    = SETUP;
        end else begin
          clearing_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobe and response flags are registered from the next state so the latch side sees clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stb_cnt     <= '0;
      word_cnt    <= '0;
      clear_busy  <= 1'b0;
      mem_op      <= 1'b0;
      mem_select  <= 1'b0;
      mem_address <= '0;
      mem_in_bus  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_n;
      stb_cnt     <= stb_cnt_n;
      word_cnt    <= word_cnt_n;
      clear_busy  <= clearing_n;
      mem_op      <= op_n;
      mem_address <= addr_n;
      mem_in_bus  <= data_n;
      mem_select  <= (state_n == STROBE);
      rsp_valid_q <= (state_n == HOLD) && !op_n;
      if ((state == STROBE) && stb_last && !mem_op)
        rsp_rdata_q <= mem_out_bus;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a word-array reference model, with a latch-array stand-in for Memory_unit.
// A second instance with STROBE_CYCLES=3 checks strobe width and clear duration.
module tb_mem_access_ctrl;
  localparam int S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- main instance, STROBE_CYCLES = 1 ----------------
  logic       rst_n, clear_start, clear_busy, mem_op, mem_select;
  logic [2:0] mem_address;
  logic [7:0] mem_in_bus, mem_out_bus;
  logic [7:0] mem_arr [8];

  mem_access_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(3), .STROBE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus.slave),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_op(mem_op), .mem_select(mem_select), .mem_address(mem_address),
    .mem_in_bus(mem_in_bus), .mem_out_bus(mem_out_bus)
  );

  always @(mem_select or mem_op or mem_address or mem_in_bus)
    if (mem_select && mem_op) mem_arr[mem_address] = mem_in_bus;
  assign mem_out_bus = mem_arr[mem_address];

  // Strobe-shape monitor: width, and address/data/op stable around each pulse.
  bit          mon_en = 1'b1;
  int          sel_run = 0;
  logic        p_sel = 1'b0;
  logic [11:0] p_cfg = '0;
  logic [11:0] pulses [$];

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      sel_run = 0;
    end else if (mem_select) begin
      if (!p_sel) begin
        chk("setup_stable", 32'({mem_op, mem_address, mem_in_bus}), 32'(p_cfg));
        pulses.push_back({mem_op, mem_address, mem_in_bus});
      end else begin
        chk("strobe_stable", 32'({mem_op, mem_address, mem_in_bus}), 32'(p_cfg));
      end
      sel_run++;
    end else if (p_sel) begin
      chk("hold_stable", 32'({mem_op, mem_address, mem_in_bus}), 32'(p_cfg));
      chk("sel_width", 32'(sel_run), 32'(S));
      sel_run = 0;
    end
    p_sel = mem_select;
    p_cfg = {mem_op, mem_address, mem_in_bus};
  end

  logic [7:0] ref_mem [8];
  bit         ref_known [8];
  logic [7:0] last_rd = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [2:0] a, input logic [7:0] d, input bit poke);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    #1;
    while (!bus.req_ready && n < 200) begin step(); n++; end
    chk("accept", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 2 + S; c++) begin
      chk("rdy_low", 32'(bus.req_ready), 32'd0);
      chk("rsp_vld", 32'(bus.rsp_valid), 32'(!w && (c == 2 + S)));
      if (!w && c == 2 + S && ref_known[a]) begin
        chk("rdata", 32'(bus.rsp_rdata), 32'(ref_mem[a]));
        last_rd = ref_mem[a];
      end
      if (poke) chk("clear_ignored", 32'(clear_busy), 32'd0);
      if (poke && c == 1) clear_start = 1'b1;
      if (poke && c == 2) clear_start = 1'b0;
      step();
    end
    chk("rdy_back", 32'(bus.req_ready), 32'd1);
    if (w) begin
      chk("rdata_held", 32'(bus.rsp_rdata), 32'(last_rd));
      ref_mem[a] = d;
      ref_known[a] = 1'b1;
    end
  endtask

  // Zero-fill; optionally with a read of word 4 pending on the request port.
  task automatic do_clear(input bit with_req);
    int n = 0;
    pulses.delete();
    if (with_req) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'd4;
    end
    clear_start = 1'b1;
    #1;
    chk("rdy_clear_start", 32'(bus.req_ready), 32'd0);
    step();
    clear_start = 1'b0;
    while (clear_busy && n < 400) begin
      if (with_req) chk("rdy_during_clear", 32'(bus.req_ready), 32'd0);
      n++;
      step();
    end
    chk("clear_len", 32'(n), 32'(8 * (2 + S)));
    chk("clear_pulses", 32'(pulses.size()), 32'd8);
    foreach (pulses[i]) chk("clear_word", 32'(pulses[i]), 32'({1'b1, 3'(i), 8'h00}));
    for (int i = 0; i < 8; i++) begin
      chk("mem_zero", 32'(mem_arr[i]), 32'd0);
      ref_mem[i] = 8'h00;
      ref_known[i] = 1'b1;
    end
  endtask

  // ---------------- second instance, STROBE_CYCLES = 3 ----------------
  logic       rst3_n, clear3, clear_busy3, mem_op3, mem_select3;
  logic [2:0] mem_address3;
  logic [7:0] mem_in_bus3, mem_out_bus3;
  logic [7:0] mem3 [8];
  bit         done3 = 1'b0;

  mem_access_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus3 ();

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(3), .STROBE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req(bus3.slave),
    .clear_start(clear3), .clear_busy(clear_busy3),
    .mem_op(mem_op3), .mem_select(mem_select3), .mem_address(mem_address3),
    .mem_in_bus(mem_in_bus3), .mem_out_bus(mem_out_bus3)
  );

  always @(mem_select3 or mem_op3 or mem_address3 or mem_in_bus3)
    if (mem_select3 && mem_op3) mem3[mem_address3] = mem_in_bus3;
  assign mem_out_bus3 = mem3[mem_address3];

  task automatic acc3(input logic w, input logic [2:0] a, input logic [7:0] d,
                      output int selc, output int rspc, output logic [7:0] rd);
    selc = 0; rspc = 0; rd = '0;
    bus3.req_valid = 1'b1; bus3.req_write = w; bus3.req_addr = a; bus3.req_wdata = d;
    #1;
    chk("s3_ready", 32'(bus3.req_ready), 32'd1);
    step();
    bus3.req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      selc += int'(mem_select3);
      if (bus3.rsp_valid) begin rspc++; rd = bus3.rsp_rdata; end
      step();
    end
    chk("s3_rdy_back", 32'(bus3.req_ready), 32'd1);
  endtask

  initial begin
    int n, sel, rises, selc, rspc;
    logic prev;
    logic [7:0] rd;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
    clear3 = 1'b0; rst3_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst3_n = 1'b1;
    step();
    clear3 = 1'b1;
    step();
    clear3 = 1'b0;
    n = 0; sel = 0; rises = 0; prev = 1'b0;
    while (clear_busy3 && n < 400) begin
      n++;
      sel += int'(mem_select3);
      if (mem_select3 && !prev) rises++;
      prev = mem_select3;
      step();
    end
    chk("s3_clear_len", 32'(n), 32'd40);
    chk("s3_sel_cycles", 32'(sel), 32'd24);
    chk("s3_pulses", 32'(rises), 32'd8);
    acc3(1'b1, 3'd5, 8'hA5, selc, rspc, rd);
    chk("s3_wr_sel", 32'(selc), 32'd3);
    chk("s3_wr_rsp", 32'(rspc), 32'd0);
    acc3(1'b0, 3'd5, 8'h00, selc, rspc, rd);
    chk("s3_rd_sel", 32'(selc), 32'd3);
    chk("s3_rd_rsp", 32'(rspc), 32'd1);
    chk("s3_rd_data", 32'(rd), 32'hA5);
    done3 = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    clear_start = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 8; i++) ref_known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'({mem_select, mem_op, mem_address, mem_in_bus, bus.rsp_valid,
                          bus.rsp_rdata, clear_busy}), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    step();

    do_clear(1'b0);

    do_req(1'b1, 3'd0, 8'h55, 1'b0);
    do_req(1'b0, 3'd0, 8'h00, 1'b0);
    do_req(1'b1, 3'd4, 8'hF0, 1'b1);
    do_req(1'b0, 3'd4, 8'h00, 1'b0);
    do_req(1'b0, 3'd0, 8'h00, 1'b0);

    do_clear(1'b1);
    do_req(1'b0, 3'd4, 8'h00, 1'b0);

    repeat (40) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
    end

    // Reset landing in the STROBE cycle of a write to word 2.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd2; bus.req_wdata = 8'h3C;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("sel_before_rst", 32'(mem_select), 32'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({mem_select, mem_op, mem_address, mem_in_bus, bus.rsp_valid,
                              bus.rsp_rdata, clear_busy}), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    last_rd = '0;
    ref_known[2] = 1'b0;
    for (int i = 0; i < 8; i++)
      if (i != 2) do_req(1'b0, 3'(i), 8'h00, 1'b0);

    n = 0;
    while (!done3 && n < 1000) begin step(); n++; end
    chk("s3_done", 32'(done3), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencing front-end that sits directly upstream of Memory_unit, the 8x8 NAND-latch word array with op/select/address/in_bus/out_bus.
- Converts a clocked valid/ready request stream into glitch-free latch strobes: address, data and op are set up, select is pulsed, then everything is held.
- Captures read data into a register and returns it on a one-cycle response.
- Provides a clear sequencer that writes zero to every word, because latch contents are undefined after power-up.

Parameters:
- DATA_W, 8, word width; must match Memory_unit bus width.
- ADDR_W, 3, address width; depth = 2**ADDR_W words.
- STROBE_CYCLES, 1, number of cycles mem_select stays high per access; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- clear_start  input  1  single-cycle pulse; starts the zero-fill of all words.
- clear_busy  output  1  high while the clear sequence runs.
- rsp_valid  output  1  one-cycle pulse; read data is valid.
- rsp_rdata  output  DATA_W  captured read data, held until the next read capture.
- mem_op  output  1  to Memory_unit op (1 = write, 0 = read).
- mem_select  output  1  to Memory_unit select.
- mem_address  output  ADDR_W  to Memory_unit address.
- mem_in_bus  output  DATA_W  to Memory_unit in_bus.
- mem_out_bus  input  DATA_W  from Memory_unit out_bus.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. All outputs are 0: mem_select, mem_op, mem_address, mem_in_bus, rsp_valid, rsp_rdata, clear_busy. req_ready is 0 while rst_n is low and 1 in the first cycle after release.
- All mem_* outputs are driven directly from flops; no combinational path from any input to mem_select.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - req_ready = 1 only when clear_start = 0.
  - clear_start = 1: load word counter = 0, set clear_busy, go to SETUP with op = 1 and data = 0. clear_start has priority over req_valid.
  - Otherwise, req_valid & req_ready: register write, addr and wdata, then go to SETUP.
- SETUP (1 cycle): mem_address, mem_in_bus and mem_op drive the registered values; mem_select = 0. Go to STROBE.
- STROBE (STROBE_CYCLES cycles): mem_select = 1 with address, data and op unchanged. For a read, rsp_rdata <= mem_out_bus on the clock edge that ends the last STROBE cycle. Go to HOLD.
- HOLD (1 cycle): mem_select = 0 with address, data and op still held. rsp_valid = 1 in this cycle for reads only; a write produces no response.
  - Not clearing: go to IDLE.
  - Clearing and counter < 2**ADDR_W-1: increment counter, go to SETUP.
  - Clearing and counter = 2**ADDR_W-1: drop clear_busy, go to IDLE.
- After HOLD, mem_address, mem_in_bus and mem_op keep their last values in IDLE; only mem_select returns to 0.
- Timing with request accepted at edge E0:
  - SETUP occupies cycle 1, STROBE cycles 2..1+STROBE_CYCLES, HOLD the next cycle, and req_ready is high again the cycle after HOLD.
  - Throughput is one access per 3+STROBE_CYCLES cycles.
  - Clear takes 2**ADDR_W * (2+STROBE_CYCLES) cycles after the clear_start edge; with defaults that is 24 cycles.
- Boundaries:
  - req_valid outside IDLE is not accepted; the requester must hold the request stable until the req_ready handshake.
  - clear_start outside IDLE is ignored, with no queueing.
  - Counter wrap-around: the counter stops at 7; it never wraps to 0 and never restarts.
  - Reset mid-STROBE: mem_select falls asynchronously. The word addressed at that moment is undefined; every other word retains its value.
  - Reads of never-written or never-cleared words return X from the array; the controller passes them through unmodified.

Test Plan:
- Reset, then a clear_start pulse -> clear_busy high for 24 cycles; mem_select pulses 8 times with mem_address 0,1,...,7, mem_op = 1, mem_in_bus = 0x00; every stored word = 0x00 afterwards.
- Write addr 0 data 0x55, then read addr 0 -> mem_select high exactly 1 cycle per access with address and data stable one cycle before and after; rsp_valid pulses once; rsp_rdata = 0x55.
- Write addr 4 data 0xF0, read addr 4, read addr 0 -> rsp_rdata = 0xF0, then 0x55; req_ready low for 3 cycles after each accept.
- clear_start and req_valid asserted in the same IDLE cycle -> clear runs and req_ready stays low; after clear_busy falls the pending read of addr 4 returns 0x00.
- Assert rst_n low in the STROBE cycle of a write to addr 2 -> mem_select = 0 immediately and all outputs = 0; after release and reading the other addresses, all previously written words are unchanged.
- Rerun with STROBE_CYCLES = 3 -> mem_select high for 3 consecutive cycles per access; clear takes 40 cycles.
